// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported unified memory between the
// instruction-fetch port and the data port. One access is outstanding at a
// time. Address and controls are held stable until the memory acknowledges
// or the wait counter expires. Read data returns with a one-cycle ready pulse.
//
// Optional feature: define ARB_RR_EN to replace the fixed data-over-fetch
// priority with a 1-bit round-robin pointer.
module mem_port_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [3:0]  dm_be,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_ready,
    output logic        mem_en,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        stall_if,
    output logic        stall_mem,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter value seen in the last BUSY cycle allowed before aborting.
    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    state_t      state;
    state_t      state_next;

    logic [31:0] hold_addr;
    logic [31:0] hold_wdata;
    logic [3:0]  hold_be;
    logic        hold_we;
    logic        owner_dm;     // 1: data port owns the access, 0: fetch port
    logic [7:0]  wait_cnt;

    logic        any_req;
    logic        grant_dm;
    logic        timeout_hit;

    assign any_req     = if_req | dm_req;
    assign timeout_hit = (wait_cnt == LAST_WAIT);

`ifdef ARB_RR_EN
    logic rr_dm;               // 1: data port wins the next tie

    // Round-robin pointer flips away from whoever just completed.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            rr_dm <= 1'b1;
        end else if (state == DONE) begin
            rr_dm <= ~owner_dm;
        end
    end

    assign grant_dm = dm_req & (~if_req | rr_dm);
`else
    // The MEM-stage instruction is older than the one being fetched.
    assign grant_dm = dm_req;
`endif

    // State register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; mem_ack only matters while BUSY.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (any_req) state_next = BUSY;
            BUSY:    if (mem_ack || timeout_hit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Hold registers latch the winner in IDLE so requester changes are ignored.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            hold_addr  <= '0;
            hold_wdata <= '0;
            hold_be    <= '0;
            hold_we    <= 1'b0;
            owner_dm   <= 1'b0;
        end else if (state == IDLE && any_req) begin
            owner_dm <= grant_dm;
            if (grant_dm) begin
                hold_addr  <= dm_addr;
                hold_wdata <= dm_wdata;
                hold_be    <= dm_be;
                hold_we    <= dm_we;
            end else begin
                hold_addr <= if_addr;
                hold_be   <= 4'b1111;
                hold_we   <= 1'b0;
            end
        end
    end

    // Wait counter clears on BUSY entry and counts BUSY cycles without ack.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            wait_cnt <= '0;
        end else if (state == IDLE) begin
            wait_cnt <= '0;
        end else if (state == BUSY && !mem_ack) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    // Read data capture on ack, all-ones on timeout; the error flag is sticky.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            if_rdata <= '0;
            dm_rdata <= '0;
            err      <= 1'b0;
        end else if (state == BUSY) begin
            if (mem_ack) begin
                if (!hold_we) begin
                    if (owner_dm) dm_rdata <= mem_rdata;
                    else          if_rdata <= mem_rdata;
                end
            end else if (timeout_hit) begin
                err <= 1'b1;
                if (!hold_we) begin
                    if (owner_dm) dm_rdata <= 32'hFFFF_FFFF;
                    else          if_rdata <= 32'hFFFF_FFFF;
                end
            end
        end
    end

    assign mem_en    = (state == BUSY);
    assign mem_we    = hold_we & mem_en;
    assign mem_be    = hold_be;
    assign mem_addr  = hold_addr;
    assign mem_wdata = hold_wdata;

    assign if_ready  = (state == DONE) & ~owner_dm;
    assign dm_ready  = (state == DONE) &  owner_dm;

    assign stall_if  = if_req & ~if_ready;
    assign stall_mem = dm_req & ~dm_ready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter, built with TIMEOUT = 4.
module tb_mem_port_arbiter;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        dm_req = 1'b1;
    logic        dm_we = 1'b0;
    logic [3:0]  dm_be = 4'hF;
    logic [31:0] dm_addr = 32'h0000_0123;
    logic [31:0] dm_wdata = '0;
    logic [31:0] dm_rdata;
    logic        dm_ready;
    logic        mem_en;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic        stall_if;
    logic        stall_mem;
    logic        err;

    int n_vec  = 0;
    int n_miss = 0;

    mem_port_arbiter #(.TIMEOUT(4)) dut (
        .Clk(Clk), .Reset(Reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ready(dm_ready),
        .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .stall_if(stall_if), .stall_mem(stall_mem), .err(err)
    );

    always #5 Clk = ~Clk;

    // Memory model: acks in the ack_delay-th cycle of mem_en (0 = never).
    int          ack_delay = 1;
    logic        force_ack = 1'b0;
    logic [31:0] mem_data_val = '0;
    int          busy_seen = 0;

    always @(posedge Clk) begin
        #2;
        if (mem_en && ack_delay != 0) begin
            busy_seen = busy_seen + 1;
            mem_ack   = (busy_seen == ack_delay) || force_ack;
        end else begin
            busy_seen = 0;
            mem_ack   = force_ack;
        end
        mem_rdata = mem_data_val;
    end

    typedef struct {
        logic        is_dm;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;      // value the memory returns
        int          delay;      // ack cycle within BUSY, 0 = never
        logic        chg;        // disturb requester inputs mid-access
        logic [3:0]  exp_be;
        logic [31:0] exp_rdata;  // requester rdata after the access
        int          exp_busy;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Runs one access from a negedge to the negedge after its ready pulse.
    task automatic do_access(input vec_t v);
        int   busy;
        bit   got;
        logic rdy;
        logic [31:0] rd;
        busy = 0;
        got  = 0;
        ack_delay    = v.delay;
        mem_data_val = v.rdata;
        if (v.is_dm) begin
            dm_req = 1'b1; dm_we = v.we; dm_be = v.be; dm_addr = v.addr; dm_wdata = v.wdata;
        end else begin
            if_req = 1'b1; if_addr = v.addr;
        end
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge Clk);
            rdy = v.is_dm ? dm_ready : if_ready;
            if (mem_en) begin
                busy++;
                chk("busy_addr", mem_addr, v.addr);
                chk("busy_be", {28'd0, mem_be}, {28'd0, v.exp_be});
                chk("busy_we", {31'd0, mem_we}, {31'd0, v.we});
                chk("busy_stall", {31'd0, v.is_dm ? stall_mem : stall_if}, 32'd1);
                if (v.we) chk("busy_wdata", mem_wdata, v.wdata);
                if (v.chg && busy == 1) begin
                    dm_addr  = v.addr ^ 32'hFFFF_0000;
                    dm_be    = ~v.be;
                    dm_wdata = ~v.wdata;
                    if_addr  = v.addr + 32'd4;
                end
            end
            if (rdy) begin
                got = 1;
                rd = v.is_dm ? dm_rdata : if_rdata;
                chk("ready_rdata", rd, v.exp_rdata);
                chk("ready_stall", {31'd0, v.is_dm ? stall_mem : stall_if}, 32'd0);
                chk("ready_en_low", {31'd0, mem_en}, 32'd0);
                if (v.is_dm) dm_req = 1'b0;
                else         if_req = 1'b0;
            end
        end
        if (!got) chk("ready_wait", 32'd0, 32'd1);
        chk("busy_cycles", busy, v.exp_busy);
        @(negedge Clk);
        chk("pulse_once", {30'd0, if_ready, dm_ready}, 32'd0);
        chk("idle_en", {31'd0, mem_en}, 32'd0);
    endtask

`ifdef ARB_RR_EN
    localparam logic [3:0] EXP_SEQ = 4'b0101;   // DM, IF, DM, IF (bit0 first)
`else
    localparam logic [3:0] EXP_SEQ = 4'b1111;   // DM always wins
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          ngrant;
        int          if_p;
        int          dm_p;
        int          nrdy;
        logic        prev_en;
        logic [31:0] grants[2];
        logic [3:0]  seqv;
        vec_t        tv;

        //            dm we be     addr          wdata         rdata         dly chg expbe  exp_rdata     busy
        vecs[0] = '{1'b0, 1'b0, 4'hF, 32'h0000_0010, 32'h0, 32'h2008_0005, 2, 1'b0, 4'hF, 32'h2008_0005, 2};
        vecs[1] = '{1'b1, 1'b1, 4'h4, 32'h0000_0102, 32'h0000_AB00, 32'hDEAD_BEEF, 2, 1'b1, 4'h4, 32'h0000_0000, 2};
        vecs[2] = '{1'b1, 1'b0, 4'hF, 32'h0000_0200, 32'h0, 32'h1234_5678, 1, 1'b0, 4'hF, 32'h1234_5678, 1};
        vecs[3] = '{1'b1, 1'b1, 4'hC, 32'h0000_0302, 32'hBEEF_0000, 32'h5555_5555, 3, 1'b1, 4'hC, 32'h1234_5678, 3};
        vecs[4] = '{1'b0, 1'b0, 4'hF, 32'h0000_0014, 32'h0, 32'hA5A5_0F0F, 3, 1'b1, 4'hF, 32'hA5A5_0F0F, 3};
        vecs[5] = '{1'b1, 1'b1, 4'hF, 32'h0000_0400, 32'h0102_0304, 32'h9999_9999, 1, 1'b0, 4'hF, 32'h1234_5678, 1};
        vecs[6] = '{1'b0, 1'b0, 4'hF, 32'hFFFF_FFFC, 32'h0, 32'h0000_0000, 1, 1'b0, 4'hF, 32'h0000_0000, 1};

        // Reset held two cycles with a pending data request.
        @(negedge Clk);
        @(negedge Clk);
        chk("rst_en", {31'd0, mem_en}, 32'd0);
        chk("rst_ready", {30'd0, if_ready, dm_ready}, 32'd0);
        chk("rst_we_be", {27'd0, mem_we, mem_be}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_dm_rdata", dm_rdata, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        Reset = 1'b0;
        dm_req = 1'b0;
        @(negedge Clk);
        chk("post_rst_idle", {31'd0, mem_en}, 32'd0);

        for (int i = 0; i < 7; i++) do_access(vecs[i]);

        // Contention: both requests rise together, acks after 3 cycles.
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        ack_delay = 3;
        mem_data_val = 32'h0BAD_F00D;
        if_req = 1'b1; if_addr = 32'h0000_0020;
        dm_req = 1'b1; dm_we = 1'b0; dm_be = 4'hF; dm_addr = 32'h0000_0500;
        ngrant = 0; if_p = 0; dm_p = 0; prev_en = 1'b0;
        grants[0] = '0; grants[1] = '0;
        for (int c = 0; c < 30; c++) begin
            @(negedge Clk);
            if (mem_en && !prev_en) begin
                if (ngrant < 2) grants[ngrant] = mem_addr;
                ngrant++;
            end
            prev_en = mem_en;
            if (if_ready || dm_ready) begin
                chk("cont_done_en", {31'd0, mem_en}, 32'd0);
                chk("cont_one_ready", {31'd0, if_ready & dm_ready}, 32'd0);
            end
            if (dm_ready && dm_p == 0 && if_p == 0)
                chk("cont_loser_stall", {31'd0, stall_if}, 32'd1);
            if (if_ready) begin if_p++; if_req = 1'b0; end
            if (dm_ready) begin dm_p++; dm_req = 1'b0; end
        end
        chk("cont_grants", ngrant, 2);
        chk("cont_first", grants[0], 32'h0000_0500);
        chk("cont_second", grants[1], 32'h0000_0020);
        chk("cont_if_pulses", if_p, 1);
        chk("cont_dm_pulses", dm_p, 1);
        chk("cont_if_rdata", if_rdata, 32'h0BAD_F00D);
        chk("cont_dm_rdata", dm_rdata, 32'h0BAD_F00D);

        // Persistent contention: four grants with both requests held.
        ack_delay = 1;
        mem_data_val = 32'h7777_0001;
        if_req = 1'b1; dm_req = 1'b1;
        nrdy = 0; seqv = '0;
        for (int c = 0; c < 40 && nrdy < 4; c++) begin
            @(negedge Clk);
            if (if_ready || dm_ready) begin
                chk("rr_one_ready", {31'd0, if_ready & dm_ready}, 32'd0);
                seqv[nrdy] = dm_ready;
                nrdy++;
                if (nrdy == 4) begin
                    if_req = 1'b0;
                    dm_req = 1'b0;
                end
            end
        end
        chk("rr_count", nrdy, 4);
        chk("rr_sequence", {28'd0, seqv}, {28'd0, EXP_SEQ});
        @(negedge Clk);

        // Timeout: data load never acked.
        tv = '{1'b1, 1'b0, 4'hF, 32'h0000_0600, 32'h0, 32'h0000_0000, 0, 1'b0, 4'hF, 32'hFFFF_FFFF, 4};
        do_access(tv);
        chk("to_err", {31'd0, err}, 32'd1);

        // A normal fetch after the timeout still completes; err stays set.
        tv = '{1'b0, 1'b0, 4'hF, 32'h0000_0030, 32'h0, 32'h1357_9BDF, 1, 1'b0, 4'hF, 32'h1357_9BDF, 1};
        do_access(tv);
        chk("to_err_sticky", {31'd0, err}, 32'd1);

        // Reset in the second BUSY cycle, then a late ack.
        ack_delay = 0;
        mem_data_val = 32'hCAFE_0001;
        dm_req = 1'b1; dm_we = 1'b0; dm_be = 4'hF; dm_addr = 32'h0000_0700;
        @(negedge Clk);
        chk("rma_busy1", {31'd0, mem_en}, 32'd1);
        @(negedge Clk);
        chk("rma_busy2", {31'd0, mem_en}, 32'd1);
        Reset = 1'b1;
        dm_req = 1'b0;
        @(negedge Clk);
        chk("rma_en", {31'd0, mem_en}, 32'd0);
        chk("rma_ready", {30'd0, if_ready, dm_ready}, 32'd0);
        chk("rma_err", {31'd0, err}, 32'd0);
        chk("rma_addr", mem_addr, 32'd0);
        Reset = 1'b0;
        force_ack = 1'b1;
        @(negedge Clk);
        force_ack = 1'b0;
        chk("rma_late_en", {31'd0, mem_en}, 32'd0);
        chk("rma_late_ready", {30'd0, if_ready, dm_ready}, 32'd0);
        @(negedge Clk);
        chk("rma_ack_ignored_en", {31'd0, mem_en}, 32'd0);
        chk("rma_ack_ignored_ready", {30'd0, if_ready, dm_ready}, 32'd0);
        chk("rma_dm_rdata", dm_rdata, 32'd0);
        chk("rma_if_rdata", if_rdata, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter and sequencer that shares one single-ported unified memory between the pipeline's instruction-fetch port (IF stage) and data port (MEM stage). It grants one requester at a time and holds the memory address and controls stable until the memory acknowledges. It returns read data to the granted requester with a one-cycle ready pulse. Stall outputs feed the hazard logic so the PC, IF/ID and later pipeline registers freeze while an access is outstanding.

## Interface
- `TIMEOUT`, 255: maximum number of BUSY cycles without `mem_ack` before the access is aborted; range 1–255.
- `Clk` in 1: system clock, rising edge.
- `Reset` in 1: synchronous, active-high reset.
- `if_req` in 1: fetch request; held high until `if_ready`.
- `if_addr` in 32: fetch word address.
- `if_rdata` out 32: registered fetch data.
- `if_ready` out 1: one-cycle pulse when the fetch completes.
- `dm_req` in 1: data request; held high until `dm_ready`.
- `dm_we` in 1: 1 = store, 0 = load.
- `dm_be` in 4: byte enables for stores (byte = 0001<<a[1:0], half = 0011<<a[1:0], word = 1111).
- `dm_addr` in 32: data address.
- `dm_wdata` in 32: store data.
- `dm_rdata` out 32: registered load data.
- `dm_ready` out 1: one-cycle pulse when the data access completes.
- `mem_en` out 1: memory access strobe.
- `mem_we` out 1: memory write enable.
- `mem_be` out 4: memory byte enables.
- `mem_addr` out 32: memory address.
- `mem_wdata` out 32: memory write data.
- `mem_rdata` in 32: memory read data; valid in the `mem_ack` cycle.
- `mem_ack` in 1: memory completion, one cycle.
- `stall_if` out 1: `if_req & ~if_ready`.
- `stall_mem` out 1: `dm_req & ~dm_ready`.
- `err` out 1: sticky flag, set on timeout.

## Operation
- The FSM has three states: IDLE, BUSY, DONE.
- **IDLE:** requests are sampled.
  - If neither requester is asking, stay in IDLE.
  - Otherwise select a winner. Latch the winner's address, we, be and wdata into the hold registers and record the owner (IF or DM). Go to BUSY.
  - On a fetch grant, `mem_we` = 0 and `mem_be` = 1111.
- **BUSY:**
  - `mem_en` = 1. `mem_*` are driven only from the hold registers, so later changes on the requester inputs are ignored.
  - On `mem_ack`:
    - If the owner's access is a read, capture `mem_rdata` into the owner's rdata register. Stores leave `dm_rdata` unchanged.
    - Go to DONE.
  - If the wait counter reaches `TIMEOUT` with no ack, set `err`, load 0xFFFF_FFFF into the owner's rdata register if the access was a read, and go to DONE. The pipeline is therefore never hung.
- **DONE:**
  - Assert the owner's ready for exactly one cycle. Requests are ignored in this cycle, because the requester's req is still high until the next clock edge.
  - Return to IDLE.
- **Arbitration (default):** fixed priority, data over fetch. The MEM-stage instruction is older than the one being fetched.
- `mem_ack` is ignored outside BUSY.
- `err` clears only on `Reset`.
- The wait counter is 8 bits. It clears on entry to BUSY and increments each BUSY cycle without ack.

## Timing
- Reset values:
  - State IDLE.
  - `mem_en`, `mem_we`, `if_ready`, `dm_ready`, `err` = 0.
  - `mem_be` = 0000.
  - `mem_addr`, `mem_wdata`, `if_rdata`, `dm_rdata` = 0.
  - Wait counter = 0.
  - Round-robin pointer = DM (when ARB_RR_EN is compiled in).
- `Reset` asserted in BUSY or DONE aborts immediately. No ready pulse is produced and the access is lost; the pipeline is reset too.
- Request sampled in IDLE at cycle t:
  - `mem_en` is high from t+1.
  - Earliest `mem_ack` is at t+1.
  - Ready pulses at ack cycle + 1.
  - Minimum latency from request to ready is 2 cycles; best-case back-to-back throughput is 1 access per 3 cycles.
- On timeout: BUSY lasts `TIMEOUT` cycles, then DONE follows.
- Both requests high in IDLE: only one grant per cycle. The loser stays stalled and is re-arbitrated in the IDLE cycle after DONE.
- `mem_en` falls in the DONE cycle. `mem_addr` holds its last value until the next grant.

## Configuration
- `ARB_RR_EN` defined: when both requests are high in IDLE, grant the requester indicated by a 1-bit round-robin pointer. After each completed grant, the pointer flips to the other requester. A lone requester is always granted and still flips the pointer.
- `ARB_RR_EN` undefined: fixed priority, data over fetch; no pointer register exists.

## Test plan
- **Reset:** hold `Reset` for 2 cycles with `dm_req` = 1 → `mem_en` = 0, both ready = 0, all data outputs 0, `err` = 0.
- **Single fetch:** `if_req` = 1, `if_addr` = 0x0000_0010; memory acks 1 cycle after `mem_en` rises with 0x2008_0005 → `mem_addr` = 0x10, `mem_we` = 0, `mem_be` = 1111; `if_ready` pulses once; `if_rdata` = 0x2008_0005; `stall_if` falls.
- **Byte store:** `dm_req` = 1, `dm_we` = 1, `dm_be` = 0100, `dm_addr` = 0x0000_0102, `dm_wdata` = 0x0000_AB00; `dm_addr` is changed mid-BUSY → `mem_addr` stays 0x102 and `mem_be` stays 0100 for the whole access; `dm_ready` pulses once; `dm_rdata` is unchanged.
- **Contention:** `if_req` and `dm_req` rise in the same cycle; memory acks after 3 cycles →
  - Without `ARB_RR_EN`: DM is served first, then IF; each requester sees exactly one ready pulse; no duplicate grant in the DONE cycle.
  - With `ARB_RR_EN`: repeated contention alternates grants DM, IF, DM, IF.
- **Timeout:** `TIMEOUT` = 4, data load with `mem_ack` tied low → BUSY lasts 4 cycles; then `err` = 1 (sticky), `dm_rdata` = 0xFFFF_FFFF, `dm_ready` pulses; a later fetch with normal acks completes correctly.
- **Reset mid-access:** assert `Reset` in the second BUSY cycle → next cycle is IDLE with `mem_en` = 0 and no ready pulse; a late `mem_ack` after reset is ignored.
